// File: rtl/ysyx_23060184_axi_rd_arbiter_pkg.sv
// rtl/ysyx_23060184_axi_rd_arbiter_pkg.sv - shared widths and FSM state encodings for the AXI read arbiter
`ifndef YSYX_23060184_DEFINES_SV
`define YSYX_23060184_DEFINES_SV
`define NUM_ARB_MASTERS 2
`define DATA_WIDTH 32
`define ID_WIDTH 4
`define ALEN 8
`define ASIZE 3
`define ABURST 2
`define ACERR_WIDTH 2
`endif

package ysyx_23060184_defines;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_e;
endpackage

// File: rtl/ysyx_23060184_arb_picker.sv
// rtl/ysyx_23060184_arb_picker.sv - combinational one-hot winner select
// ARB_RR_EN: round-robin starting after ptr; otherwise fixed priority, highest index wins.
module ysyx_23060184_arb_picker #(
  parameter int NUM_MASTERS = `NUM_ARB_MASTERS
) (
  input  logic [NUM_MASTERS-1:0] req,
`ifdef ARB_RR_EN
  input  logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] ptr,
`endif
  output logic [NUM_MASTERS-1:0] winner
);
`ifdef ARB_RR_EN
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  logic [IDX_W-1:0] idx;
  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = IDX_W'((int'(ptr) + 1 + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (!found && req[k]) begin
        winner[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/ysyx_23060184_axi_rd_arbiter.sv
// rtl/ysyx_23060184_axi_rd_arbiter.sv - shares one AXI4 read port between IFU (0) and LSU (1)
// ARB_RR_EN selects round-robin arbitration; default is fixed priority.
module ysyx_23060184_axi_rd_arbiter
  import ysyx_23060184_defines::*;
#(
  parameter int NUM_MASTERS = `NUM_ARB_MASTERS,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ID_WIDTH    = `ID_WIDTH
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_MASTERS-1:0]            req,
  output logic [NUM_MASTERS-1:0]            grant,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_arid,
  input  logic [NUM_MASTERS*`ALEN-1:0]      m_arlen,
  input  logic [NUM_MASTERS*`ASIZE-1:0]     m_arsize,
  input  logic [NUM_MASTERS*`ABURST-1:0]    m_arburst,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [`ACERR_WIDTH-1:0]           m_rresp,
  output logic                              m_rlast,
  output logic [DATA_WIDTH-1:0]             s_araddr,
  output logic                              s_arvalid,
  output logic [ID_WIDTH-1:0]               s_arid,
  output logic [`ALEN-1:0]                  s_arlen,
  output logic [`ASIZE-1:0]                 s_arsize,
  output logic [`ABURST-1:0]                s_arburst,
  input  logic                              s_arready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic [`ACERR_WIDTH-1:0]           s_rresp,
  input  logic                              s_rlast,
  input  logic                              s_rvalid,
  output logic                              s_rready
);
  arb_state_e             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt, winner;
  logic                   g_req, g_arvalid, last_beat;

  assign g_req     = |(req & grant);
  assign g_arvalid = |(m_arvalid & grant);
  assign last_beat = (state == ARB_R) && s_rvalid && s_rready && s_rlast;

`ifdef ARB_RR_EN
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  logic [IDX_W-1:0] ptr, grant_idx;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  // Only completed transactions advance fairness; aborted AR grants leave it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          ptr <= '0;
    else if (last_beat) ptr <= grant_idx;
  end

  ysyx_23060184_arb_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );
`else
  ysyx_23060184_arb_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req    (req),
    .winner (winner)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ARB_IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          grant_nxt = winner;
          state_nxt = ARB_AR;
        end
      end
      ARB_AR: begin
        // A handshake already seen by the slave must win over a late req drop.
        if (s_arvalid && s_arready) begin
          state_nxt = ARB_R;
        end else if (!g_req) begin
          grant_nxt = '0;
          state_nxt = ARB_IDLE;
        end
      end
      ARB_R: begin
        if (last_beat) begin
          grant_nxt = '0;
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        s_araddr  = m_araddr[i*DATA_WIDTH +: DATA_WIDTH];
        s_arid    = m_arid[i*ID_WIDTH +: ID_WIDTH];
        s_arlen   = m_arlen[i*`ALEN +: `ALEN];
        s_arsize  = m_arsize[i*`ASIZE +: `ASIZE];
        s_arburst = m_arburst[i*`ABURST +: `ABURST];
      end
    end
  end

  assign s_arvalid = (state == ARB_AR) && g_arvalid;
  assign m_arready = ((state == ARB_AR) && s_arready) ? grant : '0;
  assign m_rvalid  = ((state == ARB_R) && s_rvalid) ? grant : '0;
  assign s_rready  = (state == ARB_R) && |(m_rready & grant);
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;
endmodule

// File: tb/tb_ysyx_23060184_axi_rd_arbiter.sv
// tb/tb_ysyx_23060184_axi_rd_arbiter.sv - directed self-checking bench for the AXI read arbiter
module tb_ysyx_23060184_axi_rd_arbiter;
  logic        clk;
  logic        rstn;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic [63:0] m_araddr;
  logic [1:0]  m_arvalid;
  logic [7:0]  m_arid;
  logic [15:0] m_arlen;
  logic [5:0]  m_arsize;
  logic [3:0]  m_arburst;
  logic [1:0]  m_arready;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;

  int checks = 0;
  int failures = 0;

`ifdef ARB_RR_EN
  localparam logic [1:0] EXP_SECOND = 2'b01;
  localparam logic [1:0] EXP_AFTER_ABORT = 2'b01;
`else
  localparam logic [1:0] EXP_SECOND = 2'b10;
  localparam logic [1:0] EXP_AFTER_ABORT = 2'b10;
`endif

  ysyx_23060184_axi_rd_arbiter dut (
    .clk(clk), .rstn(rstn), .req(req), .grant(grant),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  bit vpat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit rpat [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int beats;
  bit leak;
  bit lost;

  initial begin
    rstn = 1'b0; req = '0; m_araddr = '0; m_arvalid = '0; m_arid = '0; m_arlen = '0;
    m_arsize = '0; m_arburst = '0; m_rready = '0; s_arready = 1'b0; s_rdata = '0;
    s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    tick(); tick();
    check("rst_grant", grant, 2'b00);
    check("rst_arvalid", s_arvalid, 1'b0);
    check("rst_rready", s_rready, 1'b0);
    check("rst_arready", m_arready, 2'b00);
    check("rst_rvalid", m_rvalid, 2'b00);
    rstn = 1'b1;
    tick();

    // IFU alone, single-beat read
    req = 2'b01; m_arvalid = 2'b01; m_araddr[31:0] = 32'h8000_0000; m_arid[3:0] = 4'h3;
    m_arlen[7:0] = 8'd0; m_arsize[2:0] = 3'd2; m_arburst[1:0] = 2'b01;
    #1;
    check("ifu_grant_same_cycle", grant, 2'b00);
    tick();
    check("ifu_grant", grant, 2'b01);
    check("ifu_arvalid", s_arvalid, 1'b1);
    check("ifu_araddr", s_araddr, 32'h8000_0000);
    check("ifu_arid", s_arid, 4'h3);
    check("ifu_arsize", s_arsize, 3'd2);
    check("ifu_arready_wait", m_arready, 2'b00);
    s_arready = 1'b1;
    #1;
    check("ifu_arready", m_arready, 2'b01);
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hdead_beef; s_rlast = 1'b1; m_rready = 2'b01;
    #1;
    check("ifu_arvalid_in_r", s_arvalid, 1'b0);
    check("ifu_rvalid", m_rvalid, 2'b01);
    check("ifu_rready", s_rready, 1'b1);
    check("ifu_rdata", m_rdata, 32'hdead_beef);
    tick();
    check("ifu_grant_done", grant, 2'b00);
    s_rvalid = 1'b0; s_rlast = 1'b0; req = '0; m_rready = '0;
    tick();

    // Contention; first transaction returns SLVERR
    req = 2'b11; m_arvalid = 2'b11; m_araddr[63:32] = 32'h0000_1000; m_arid[7:4] = 4'h5;
    m_arlen[15:8] = 8'd0;
    tick();
    check("cont_grant1", grant, 2'b10);
    check("cont_araddr", s_araddr, 32'h0000_1000);
    check("cont_arid", s_arid, 4'h5);
    check("cont_arready_ifu", m_arready, 2'b00);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid = '0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rresp = 2'b10; m_rready = 2'b11;
    #1;
    check("err_rresp", m_rresp, 2'b10);
    check("err_rvalid", m_rvalid, 2'b10);
    check("err_rlast", m_rlast, 1'b1);
    tick();
    check("err_idle_gap", grant, 2'b00);
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00; m_arvalid = 2'b11;
    tick();
    check("cont_grant2", grant, EXP_SECOND);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
    tick();
    check("cont_grant2_done", grant, 2'b00);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    tick();
    check("cont_grant3", grant, 2'b10);

    // LSU 4-beat burst with stalls; req dropped during R must be ignored
    m_arlen[15:8] = 8'd3;
    s_arready = 1'b1;
    #1;
    check("burst_arlen", s_arlen, 8'd3);
    tick();
    s_arready = 1'b0; m_arvalid = '0; req = '0;
    beats = 0; leak = 1'b0; lost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_rvalid = vpat[i];
      m_rready = {rpat[i], 1'b1};
      s_rlast  = (beats == 3) && vpat[i];
      #1;
      if (m_rvalid[0]) leak = 1'b1;
      if (grant !== 2'b10) lost = 1'b1;
      if (m_rvalid[1] && m_rready[1]) beats++;
      tick();
    end
    check("burst_beats", beats, 4);
    check("burst_ifu_rvalid_leak", leak, 1'b0);
    check("burst_grant_held", lost, 1'b0);
    check("burst_grant_done", grant, 2'b00);
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;

    // Abort: IFU drops req before the AR handshake
    req = 2'b01; m_arvalid = 2'b01;
    tick();
    check("abort_grant", grant, 2'b01);
    check("abort_arvalid", s_arvalid, 1'b1);
    req = '0; m_arvalid = '0;
    #1;
    check("abort_no_arready", m_arready, 2'b00);
    tick();
    check("abort_grant_cleared", grant, 2'b00);
    req = 2'b11; m_arvalid = 2'b11;
    tick();
    check("abort_ptr_kept", grant, EXP_AFTER_ABORT);

    // Reset in the middle of an R burst
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid = '0; s_rvalid = 1'b1; m_rready = 2'b11;
    #1;
    check("mid_rready", s_rready, 1'b1);
    rstn = 1'b0;
    #1;
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_rready", s_rready, 1'b0);
    check("mid_rst_rvalid", m_rvalid, 2'b00);
    check("mid_rst_arvalid", s_arvalid, 1'b0);
    s_rvalid = 1'b0; req = '0; m_rready = '0;
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_grant", grant, 2'b00);
    req = 2'b01; m_arvalid = 2'b01;
    tick();
    check("post_rst_idle_grant", grant, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
